// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: programs the UART baud divisor and arbitrates two byte
// requesters onto the transmitter's register-write bus, one byte in flight at a time.
module uart_tx_scheduler #(
    parameter logic [15:0] DEFAULT_DIV = 16'hFFFF,
    parameter int unsigned START_TMO   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_div,
    input  logic        cfg_load,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [1:0]  uart_adr,
    output logic [7:0]  uart_din,
    output logic        uart_wr_en,
    input  logic        uart_tx_busy,
    output logic        grant_id,
    output logic        sched_idle,
    output logic        tx_err
);

    typedef enum logic [2:0] {
        INIT_LO    = 3'd0,
        INIT_HI    = 3'd1,
        IDLE       = 3'd2,
        SEND       = 3'd3,
        WAIT_START = 3'd4,
        WAIT_DONE  = 3'd5,
        CFG_LO     = 3'd6,
        CFG_HI     = 3'd7
    } state_t;

    localparam int TMO_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      div_r;
    logic             cfg_pend_r;
    logic [7:0]       data_r;
    logic             grant_id_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tx_err_r;

    logic             take_s;
    logic             grant_s;
    logic             set_err_s;
    logic             wr_en_s;
    logic [1:0]       adr_s;
    logic [7:0]       din_s;
    logic             rdy0_s;
    logic             rdy1_s;
    logic             idle_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= INIT_LO;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, including the round-robin grant decision.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        grant_s     = grant_id_r;
        set_err_s   = 1'b0;
        case (state_r)
            INIT_LO: state_nxt_s = INIT_HI;
            INIT_HI: state_nxt_s = IDLE;
            IDLE: begin
                if (cfg_pend_r) begin
                    state_nxt_s = CFG_LO;
                end else if (req0_valid || req1_valid) begin
                    take_s      = 1'b1;
                    state_nxt_s = SEND;
                    if (req0_valid && req1_valid) begin
                        grant_s = ~grant_id_r;
                    end else begin
                        grant_s = req1_valid;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: state_nxt_s = WAIT_START;
            WAIT_START: begin
                if (uart_tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            CFG_LO:  state_nxt_s = CFG_HI;
            CFG_HI:  state_nxt_s = IDLE;
            default: state_nxt_s = INIT_LO;
        endcase
    end

    // Output decode; address and data hold their previous value between writes.
    always_comb begin
        wr_en_s = 1'b0;
        adr_s   = uart_adr;
        din_s   = uart_din;
        rdy0_s  = 1'b0;
        rdy1_s  = 1'b0;
        idle_s  = 1'b0;
        case (state_r)
            INIT_LO: begin wr_en_s = 1'b1; adr_s = 2'd0; din_s = DEFAULT_DIV[7:0];  end
            INIT_HI: begin wr_en_s = 1'b1; adr_s = 2'd1; din_s = DEFAULT_DIV[15:8]; end
            SEND:    begin wr_en_s = 1'b1; adr_s = 2'd2; din_s = data_r;            end
            CFG_LO:  begin wr_en_s = 1'b1; adr_s = 2'd0; din_s = div_r[7:0];        end
            CFG_HI:  begin wr_en_s = 1'b1; adr_s = 2'd1; din_s = div_r[15:8];       end
            IDLE: begin
                rdy0_s = take_s & ~grant_s;
                rdy1_s = take_s & grant_s;
                idle_s = ~req0_valid & ~req1_valid & ~cfg_pend_r;
            end
            default: wr_en_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_wr_en <= 1'b0;
            uart_adr   <= 2'd0;
            uart_din   <= 8'd0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            sched_idle <= 1'b0;
        end else begin
            uart_wr_en <= wr_en_s;
            uart_adr   <= adr_s;
            uart_din   <= din_s;
            req0_ready <= rdy0_s;
            req1_ready <= rdy1_s;
            sched_idle <= idle_s;
        end
    end

    // Datapath: pending divisor, latched byte, last grant, start timeout, sticky error.
    // A cfg_load landing in CFG_HI wins over the clear so the newer divisor is still sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r      <= DEFAULT_DIV;
            cfg_pend_r <= 1'b0;
            data_r     <= 8'd0;
            grant_id_r <= 1'b1;
            tmo_cnt_r  <= '0;
            tx_err_r   <= 1'b0;
        end else begin
            if (cfg_load) begin
                div_r      <= cfg_div;
                cfg_pend_r <= 1'b1;
            end else if (state_r == CFG_HI) begin
                cfg_pend_r <= 1'b0;
            end
            if (take_s) begin
                data_r     <= grant_s ? req1_data : req0_data;
                grant_id_r <= grant_s;
            end
            if (state_r == SEND) begin
                tmo_cnt_r <= '0;
            end else if (state_r == WAIT_START) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (set_err_s) begin
                tx_err_r <= 1'b1;
            end
        end
    end

    assign grant_id = grant_id_r;
    assign tx_err   = tx_err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected register writes are queued
// as stimulus is issued and popped by an independent bus monitor.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam logic [15:0] DIV = 16'h01B2;
    localparam int          TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        cfg_load;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [1:0]  uart_adr;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        uart_tx_busy;
    logic        grant_id, sched_idle, tx_err;

    int tests = 0;
    int fails = 0;

    logic [9:0] exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       uart_en;
    logic       tx_active;

    uart_tx_scheduler #(.DEFAULT_DIV(DIV), .START_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .cfg_div(cfg_div), .cfg_load(cfg_load),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .uart_adr(uart_adr), .uart_din(uart_din), .uart_wr_en(uart_wr_en),
        .uart_tx_busy(uart_tx_busy),
        .grant_id(grant_id), .sched_idle(sched_idle), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"},  32'(uart_wr_en), 32'd0);
        check({tag, "_adr"},    32'(uart_adr),   32'd0);
        check({tag, "_din"},    32'(uart_din),   32'd0);
        check({tag, "_rdy0"},   32'(req0_ready), 32'd0);
        check({tag, "_rdy1"},   32'(req1_ready), 32'd0);
        check({tag, "_tx_err"}, 32'(tx_err),     32'd0);
        check({tag, "_idle"},   32'(sched_idle), 32'd0);
        check({tag, "_grant"},  32'(grant_id),   32'd1);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (sched_idle !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(sched_idle), 32'd1);
    endtask

    task automatic wait_busy(input string name, input int bound);
        int n = 0;
        while (uart_tx_busy !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy_timeout"}, 32'(uart_tx_busy), 32'd1);
    endtask

    // Bus monitor: every write must match the next expected {adr, din}.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (uart_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {22'd0, uart_adr, uart_din}, 32'h3FF);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {22'd0, uart_adr, uart_din}, {22'd0, e});
                end
            end
        end
    end

    // Requesters: present the head of each queue, consume it on ready.
    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'd0;  req1_data = 8'd0;
        forever begin
            @(negedge clk);
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                check("dual_ready", 32'd1, 32'd0);
            end
            if (req0_ready === 1'b1) begin
                check("grant_id_r0", 32'(grant_id), 32'd0);
                check("spurious_rdy0", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) void'(q0.pop_front());
            end
            if (req1_ready === 1'b1) begin
                check("grant_id_r1", 32'(grant_id), 32'd1);
                check("spurious_rdy1", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) void'(q1.pop_front());
            end
            req0_valid = (q0.size() > 0);
            req1_valid = (q1.size() > 0);
            if (q0.size() > 0) req0_data = q0[0];
            if (q1.size() > 0) req1_data = q1[0];
        end
    end

    // Transmitter model: busy rises 1-3 cycles after a data write and stays 2-5 cycles.
    initial begin
        int start_dly = 0;
        int hold = 0;
        logic wr_data;
        uart_tx_busy = 1'b0;
        tx_active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                uart_tx_busy = 1'b0;
                tx_active = 1'b0;
            end else begin
                wr_data = (uart_wr_en === 1'b1) && (uart_adr === 2'd2);
                if (wr_data && tx_active) begin
                    check("write_during_tx", 32'd1, 32'd0);
                end
                if (tx_active) begin
                    if (!uart_tx_busy) begin
                        if (start_dly > 0) begin
                            start_dly--;
                        end else begin
                            uart_tx_busy = 1'b1;
                            hold = int'($urandom_range(5, 2));
                        end
                    end else begin
                        hold--;
                        if (hold == 0) begin
                            uart_tx_busy = 1'b0;
                            tx_active = 1'b0;
                        end
                    end
                end
                if (wr_data && !tx_active && uart_en) begin
                    tx_active = 1'b1;
                    start_dly = int'($urandom_range(2, 0));
                end
            end
        end
    end

    initial begin
        logic [7:0] a0[6];
        logic [7:0] a1[6];
        logic [7:0] x, y, z, w;
        int n;
        rst = 1'b1; cfg_div = 16'd0; cfg_load = 1'b0; uart_en = 1'b1;

        // Reset values, then the default divisor writes.
        repeat (3) @(negedge clk);
        check_reset("rst0");
        exp_q.push_back({2'd0, DIV[7:0]});
        exp_q.push_back({2'd1, DIV[15:8]});
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("init_writes_done", 32'(exp_q.size()), 32'd0);
        check("init_idle", 32'(sched_idle), 32'd1);

        // Both requesters always valid: grants alternate starting with requester 0.
        for (int i = 0; i < 6; i++) begin
            a0[i] = 8'($urandom);
            a1[i] = 8'($urandom);
        end
        a0[0] = 8'h55;
        for (int i = 0; i < 6; i++) begin
            q0.push_back(a0[i]);
            q1.push_back(a1[i]);
            exp_q.push_back({2'd2, a0[i]});
            exp_q.push_back({2'd2, a1[i]});
        end
        drain("rr", 3000);
        wait_idle("rr", 200);

        // Divisor load during WAIT_DONE goes out before the next queued byte.
        x = 8'($urandom);
        y = 8'($urandom);
        exp_q.push_back({2'd2, x});
        exp_q.push_back({2'd0, 8'h64});
        exp_q.push_back({2'd1, 8'h03});
        exp_q.push_back({2'd2, y});
        q0.push_back(x);
        q0.push_back(y);
        wait_busy("cfg", 200);
        @(negedge clk);
        cfg_div = 16'h0364;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        drain("cfg", 500);
        wait_idle("cfg", 200);
        check("tx_err_clean", 32'(tx_err), 32'd0);

        // Busy never rises: error after exactly START_TMO cycles in WAIT_START.
        uart_en = 1'b0;
        z = 8'($urandom);
        exp_q.push_back({2'd2, z});
        q1.push_back(z);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(uart_wr_en === 1'b1 && uart_adr === 2'd2) && n < 200);
        check("tmo_write_seen", 32'(n < 200), 32'd1);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_early", 32'(tx_err), 32'd0);
        @(negedge clk);
        check("tmo_err_set", 32'(tx_err), 32'd1);
        wait_idle("tmo", 50);
        uart_en = 1'b1;
        repeat (5) @(negedge clk);
        check("tx_err_sticky", 32'(tx_err), 32'd1);

        // Reset in WAIT_DONE: outputs return to reset values and init repeats.
        w = 8'($urandom);
        exp_q.push_back({2'd2, w});
        q0.push_back(w);
        wait_busy("rst", 200);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        check("rst_mid_byte_sent", 32'(exp_q.size()), 32'd0);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        exp_q.push_back({2'd0, DIV[7:0]});
        exp_q.push_back({2'd1, DIV[15:8]});
        rst = 1'b0;
        drain("reinit", 50);
        wait_idle("reinit", 50);

        // First tie after reset goes to requester 0.
        x = 8'($urandom);
        y = 8'($urandom);
        exp_q.push_back({2'd2, x});
        exp_q.push_back({2'd2, y});
        q0.push_back(x);
        q1.push_back(y);
        drain("tie", 500);
        wait_idle("tie", 200);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16'hFFFF, meaning the baud divisor programmed after reset.
REQ-002 SHALL have parameter START_TMO, default 8, meaning the maximum cycles to wait for uart_tx_busy to rise after a data write.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports cfg_div (input, 16 bits) and cfg_load (input, 1 bit): new divisor, and a one-cycle request to program it.
REQ-006 SHALL have ports req0_valid (input, 1), req0_data (input, 8) and req0_ready (output, 1): requester 0 byte handshake.
REQ-007 SHALL have ports req1_valid (input, 1), req1_data (input, 8) and req1_ready (output, 1): requester 1 byte handshake.
REQ-008 SHALL have ports uart_adr (output, 2), uart_din (output, 8) and uart_wr_en (output, 1): write bus to the UART transmitter. Address 0 is divisor[7:0], address 1 is divisor[15:8], address 2 is the data byte.
REQ-009 SHALL have port uart_tx_busy, input, 1 bit: transmitter busy flag.
REQ-010 SHALL have ports grant_id (output, 1), sched_idle (output, 1) and tx_err (output, 1): last granted requester, idle status, and sticky timeout error.

Function
REQ-011 SHALL implement the states INIT_LO, INIT_HI, IDLE, SEND, WAIT_START, WAIT_DONE, CFG_LO and CFG_HI.
REQ-012 SHALL perform these divisor writes:
- INIT_LO writes adr 0 with DEFAULT_DIV[7:0].
- INIT_HI writes adr 1 with DEFAULT_DIV[15:8].
- Each write asserts uart_wr_en for exactly one cycle.
- The state then goes to IDLE.
REQ-013 SHALL register cfg_div into an internal div_q and set cfg_pend on any cycle where cfg_load=1, in any state except reset. A later cfg_load overwrites div_q.
REQ-014 SHALL, in IDLE with cfg_pend=1, go to CFG_LO, which writes adr 0 with div_q[7:0]. CFG_HI then writes adr 1 with div_q[15:8], clears cfg_pend and returns to IDLE. A pending configuration has priority over byte requests.
REQ-015 SHALL, in IDLE with cfg_pend=0 and at least one reqN_valid, grant one requester:
- reqN_ready pulses for one cycle.
- reqN_data is latched.
- grant_id is set to N.
- The state goes to SEND.
REQ-016 SHALL arbitrate round-robin: if both requesters are valid, grant the one not equal to grant_id; a single valid requester is granted directly.
REQ-017 SHALL, in SEND, write adr 2 with the latched byte for one cycle, clear the timeout counter, and go to WAIT_START.
REQ-018 SHALL, in WAIT_START, go to WAIT_DONE when uart_tx_busy=1. If START_TMO cycles pass without busy, it SHALL set tx_err and go to IDLE.
REQ-019 SHALL, in WAIT_DONE, go to IDLE when uart_tx_busy=0. The next grant or configuration is therefore never earlier than the cycle after busy falls.
REQ-020 SHALL drive uart_wr_en=0 in all other states. uart_adr and uart_din hold their last value when uart_wr_en=0.
REQ-021 SHALL assert sched_idle=1 only in IDLE with no valid request and cfg_pend=0.
REQ-022 SHALL leave tx_err set until reset; it is cleared only by rst.
REQ-023 SHALL keep reqN_ready=0 in every state other than IDLE. At most one ready is high per cycle.
REQ-024 SHALL treat cfg_load arriving in the same cycle as the IDLE decision as pending for the next IDLE visit; the current decision uses the old cfg_pend.

Reset
REQ-025 SHALL, while rst=1, reset the outputs as follows: uart_wr_en=0, uart_adr=0, uart_din=0, req0_ready=0, req1_ready=0, tx_err=0, sched_idle=0.
REQ-026 SHALL, while rst=1, set grant_id=1 (so requester 0 wins the first tie), cfg_pend=0 and state=INIT_LO.
REQ-027 SHALL restart at INIT_LO after a reset asserted mid-operation. Any latched byte and pending configuration are discarded.

Verification
REQ-028 SHALL cover: DEFAULT_DIV=16'h01B2, release rst -> cycle 1 wr adr0 din B2, cycle 2 wr adr1 din 01, then IDLE with sched_idle=1.
REQ-029 SHALL cover: req0_valid with data 0x55 -> req0_ready one pulse, next cycle wr adr2 din 55, no further write until busy rises then falls.
REQ-030 SHALL cover: req0 and req1 both valid continuously -> grants alternate 0,1,0,1, with each data write only after the prior busy has fallen.
REQ-031 SHALL cover: cfg_load with div 16'h0364 during WAIT_DONE -> after busy falls, wr adr0 din 64, then adr1 din 03, then the next byte.
REQ-032 SHALL cover: uart_tx_busy held 0 after a data write -> after START_TMO cycles, tx_err=1 and the state returns to IDLE.
REQ-033 SHALL cover: rst pulsed during WAIT_DONE -> outputs at reset values, then the INIT_LO/INIT_HI writes repeat.
